tile_text_writer: RTL and testbench
===================================

Name: tile_text_writer

Overview:
- Writer-side client of the tilemap tile RAM; converts a byte stream of character codes plus control codes into tile-reference writes on the tilemap CPU-side port (wr/address/din).
- Maintains a text cursor and handles wrap, CR, LF, BS and clear-screen.
- Sits between a debug/console source (HPS or test-pattern sequencer) and the tilemap's 128-column tile RAM (row stride 128, 8x8 tiles).

Parameters:
- COLS, 80, visible text columns (1..128)
- ROWS, 60, visible text rows (1..128)
- TILE_BASE, 10'd0, tile index added to the character code (10-bit wrap)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  source byte valid
- in_ready  out  1  block can accept a byte this cycle
- in_data  in  8  character or control code
- in_attr  in  4  colour attribute; sampled with in_data
- wr  out  2  byte write strobes to tilemap; always 2'b11 or 2'b00
- address  out  16  tilemap word address, {2'b00, row[6:0], col[6:0]}
- dout  out  16  tile word, {attr[3:0], 2'b00, tile[9:0]}
- cursor_col  out  7  current cursor column
- cursor_row  out  7  current cursor row
- busy  out  1  high while in CLEAR or ROWCLR

Behaviour:
- Reset (async, reset_n=0): state=IDLE; wr=0; address=0; dout=0; cursor_col=0; cursor_row=0; busy=0; in_ready=0 while reset_n is low.
- Handshake: a byte is accepted on a rising edge with in_valid&&in_ready. in_ready = (state==IDLE), combinational from state.
- States: IDLE, CLEAR, ROWCLR. All outputs are registered.
- Printable (any code not listed below):
  - One cycle after acceptance: wr=2'b11, address={row,col}, dout={attr, 2'b00, TILE_BASE+code}.
  - Cursor advances: col+1. If col==COLS-1, col=0 and a line advance follows.
  - Throughput is 1 byte/cycle; wr returns to 0 the cycle after the last write.
- 0x0D CR: col=0, no write.
- 0x0A LF: line advance, no write.
- 0x08 BS: col-1 if col>0, else unchanged, no write.
- 0x0C FF:
  - Enter CLEAR with busy=1 and in_ready=0.
  - Write space tiles {attr_ff, 2'b00, TILE_BASE+0x20} row-major from (0,0) to (ROWS-1, COLS-1): one write per cycle, exactly ROWS*COLS writes.
  - Then return to IDLE with cursor at (0,0).
  - Map cells outside COLS/ROWS are untouched.
- Line advance: row+1 if row<ROWS-1. Behaviour at row==ROWS-1 is given under Optional Feature.
- Tile index add is modulo 1024.
- Reset asserted mid-CLEAR or mid-ROWCLR: the operation aborts immediately, wr=0, and no further writes occur.
- in_valid while not ready: the byte is held by the source and not lost; no combinational path from in_valid to in_ready.

Optional Feature:
- Macro: TILE_TEXT_WRITER_ROWCLR_EN.
- Defined: a line advance at row==ROWS-1 wraps to row 0 and enters ROWCLR (busy=1, in_ready=0). ROWCLR writes COLS space tiles across row 0 with the last-sampled attr, one per cycle, then returns to IDLE.
- Undefined: a line advance at row==ROWS-1 wraps to row 0 with no clearing writes. The ROWCLR state is not generated.

Decomposition:
- Package tile_text_pkg holds:
  - state enum (IDLE, CLEAR, ROWCLR)
  - control-code constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, CH_SPACE=8'h20
  - MAP_STRIDE_LOG2=7
- One sub-module, tile_fill_counter: a row/col sweep counter with start, done and row-only mode. It is shared by CLEAR and ROWCLR.

Test Plan:
- Reset then 'A' (0x41) with attr=5, TILE_BASE=0 -> next cycle wr=2'b11, address=16'h0000, dout=16'h5041; cursor_col=1.
- 80 consecutive 'B' at row 0 -> the last write has address=16'h004F, then cursor=(col 0, row 1). Back-to-back acceptance is sustained with in_ready constantly 1.
- Sequence CR, LF, BS -> no writes. After CR cursor_col=0. After LF cursor_row incremented. BS at col 0 leaves col at 0.
- FF with attr=3 -> busy=1 for exactly 4800 cycles and exactly 4800 writes of dout=16'h3020. Addresses run 0x0000..0x004F through 0x1D80..0x1DCF. Cursor ends at (0,0).
- Cursor at row 59, LF:
  - With TILE_TEXT_WRITER_ROWCLR_EN: 80 writes to 0x0000..0x004F, then row=0.
  - Without the macro: zero writes and row=0.
- reset_n low at CLEAR write 100 -> wr=0 immediately (async). After release: IDLE, cursor (0,0), no further writes.

Source files
------------

// File: rtl/tile_text_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_text_pkg
// Purpose  : Shared types and constants for the tile text writer: FSM state
//            encoding, console control codes, tile-RAM geometry and helpers
//            that pack tilemap addresses and tile words.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tile_text_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ROWCLR = 2'd2
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // The tile RAM is always 128 words per row, whatever COLS is.
  localparam int MAP_STRIDE_LOG2 = 7;

  function automatic logic [15:0] map_addr(input logic [6:0] row,
                                           input logic [6:0] col);
    return (16'(row) << MAP_STRIDE_LOG2) | 16'(col);
  endfunction

  function automatic logic [15:0] tile_word(input logic [3:0] attr,
                                            input logic [9:0] tile);
    return {attr, 2'b00, tile};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_text_writer_fill_counter.sv
`default_nettype none
// ============================================================================
// Module   : tile_fill_counter
// Purpose  : Row-major sweep counter over the visible text area. 'start'
//            rewinds to (0,0) and latches the sweep mode; each 'step' moves to
//            the next cell. 'last' flags the final cell of the sweep: the last
//            cell of the screen, or the last cell of row 0 in row-only mode.
// Ports    : clk, reset_n        - clock, async active-low reset
//            start, row_only     - begin a sweep / sweep row 0 only
//            step                - current cell consumed, advance
//            row, col            - current cell
//            last                - current cell is the final one
// Revision : 1.0 - initial release
// ============================================================================
module tile_fill_counter #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       row_only,
  input  logic       step,
  output logic [6:0] row,
  output logic [6:0] col,
  output logic       last
);

  localparam logic [6:0] c_last_col = 7'(COLS - 1);
  localparam logic [6:0] c_last_row = 7'(ROWS - 1);

  logic [6:0] r_row;
  logic [6:0] r_col;
  logic       r_row_only;

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_col == c_last_col) && (r_row_only || (r_row == c_last_row));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_only <= 1'b0;
    end else if (start) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_only <= row_only;
    end else if (step && !last) begin
      if (r_col == c_last_col) begin
        r_col <= '0;
        r_row <= r_row + 7'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tile_text_writer
// Purpose  : Turns a console byte stream (characters plus CR/LF/BS/FF) into
//            tile-reference writes on the tilemap CPU-side port, keeping a
//            text cursor with line wrap and screen clear.
// Ports    : clk, reset_n              - clock, async active-low reset
//            in_valid/in_ready/in_data - byte stream in (ready = idle)
//            in_attr                   - colour attribute for the byte
//            wr/address/dout           - tilemap write port
//            cursor_col, cursor_row    - current cursor position
//            busy                      - clearing screen or bottom-wrap row
// Options  : TILE_TEXT_WRITER_ROWCLR_EN - when defined, a line advance off
//            the last row wraps to row 0 and blanks that row (ROWCLR state).
// Revision : 1.0 - initial release
// ============================================================================
module tile_text_writer
  import tile_text_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 60,
  parameter logic [9:0] TILE_BASE = 10'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [3:0]  in_attr,
  output logic [1:0]  wr,
  output logic [15:0] address,
  output logic [15:0] dout,
  output logic [6:0]  cursor_col,
  output logic [6:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0] c_last_col   = 7'(COLS - 1);
  localparam logic [6:0] c_last_row   = 7'(ROWS - 1);
  localparam logic [9:0] c_space_tile = TILE_BASE + 10'(CH_SPACE);

  state_t     r_state;
  logic [3:0] r_attr;        // attribute of the most recently accepted byte

  logic       w_accept;
  logic       w_is_print;
  logic       w_line_adv;
  logic       w_last_row;
  logic       w_fill_start;
  logic       w_fill_row_only;
  logic       w_fill_step;
  logic [6:0] w_fill_row;
  logic [6:0] w_fill_col;
  logic       w_fill_last;

  // Ready depends only on state (and reset), never on in_valid.
  assign in_ready = reset_n && (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

  assign w_is_print = (in_data != CH_BS) && (in_data != CH_LF) &&
                      (in_data != CH_FF) && (in_data != CH_CR);
  // LF, or a printable that lands in the last column, moves down a line.
  assign w_line_adv = (in_data == CH_LF) ||
                      (w_is_print && (cursor_col == c_last_col));
  assign w_last_row = (cursor_row == c_last_row);

`ifdef TILE_TEXT_WRITER_ROWCLR_EN
  assign w_fill_start    = w_accept &&
                           ((in_data == CH_FF) || (w_line_adv && w_last_row));
  assign w_fill_row_only = (in_data != CH_FF);
  assign w_fill_step     = (r_state == CLEAR) || (r_state == ROWCLR);
`else
  assign w_fill_start    = w_accept && (in_data == CH_FF);
  assign w_fill_row_only = 1'b0;
  assign w_fill_step     = (r_state == CLEAR);
`endif

  tile_fill_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_fill (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (w_fill_start),
    .row_only (w_fill_row_only),
    .step     (w_fill_step),
    .row      (w_fill_row),
    .col      (w_fill_col),
    .last     (w_fill_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_attr     <= '0;
      wr         <= 2'b00;
      address    <= '0;
      dout       <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      busy       <= 1'b0;
    end else begin
      wr <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_attr <= in_attr;
            case (in_data)
              CH_CR: cursor_col <= '0;
              CH_LF: begin
                // Row movement is shared with the wrapping printable below.
              end
              CH_BS: begin
                if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
              end
              CH_FF: begin
                r_state <= CLEAR;
                busy    <= 1'b1;
              end
              default: begin
                wr         <= 2'b11;
                address    <= map_addr(cursor_row, cursor_col);
                dout       <= tile_word(in_attr, TILE_BASE + 10'(in_data));
                cursor_col <= (cursor_col == c_last_col) ? 7'd0
                                                         : cursor_col + 7'd1;
              end
            endcase
            if (w_line_adv) begin
              cursor_row <= w_last_row ? 7'd0 : cursor_row + 7'd1;
`ifdef TILE_TEXT_WRITER_ROWCLR_EN
              if (w_last_row) begin
                r_state <= ROWCLR;
                busy    <= 1'b1;
              end
`endif
            end
          end
        end

`ifdef TILE_TEXT_WRITER_ROWCLR_EN
        CLEAR, ROWCLR: begin
`else
        CLEAR: begin
`endif
          // One space tile per cycle; the write lags busy by one cycle, so
          // busy and wr are each high for exactly one cycle per cell.
          wr      <= 2'b11;
          address <= map_addr(w_fill_row, w_fill_col);
          dout    <= tile_word(r_attr, c_space_tile);
          if (w_fill_last) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            if (r_state == CLEAR) begin
              cursor_col <= '0;
              cursor_row <= '0;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_text_writer
// Purpose  : Self-checking bench for tile_text_writer. A reference model of
//            the console rules queues the expected tile writes; a monitor
//            pops and compares every write the design emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_text_writer;

  localparam int COLS    = 80;
  localparam int ROWS    = 60;
  localparam int TB_BASE = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_attr;
  logic [1:0]  wr;
  logic [15:0] address;
  logic [15:0] dout;
  logic [6:0]  cursor_col;
  logic [6:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  tile_text_writer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .TILE_BASE (10'(TB_BASE))
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_attr    (in_attr),
    .wr         (wr),
    .address    (address),
    .dout       (dout),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  int          stall    = 0;
  logic [31:0] exp_q[$];     // {address, dout}
  int          mcol     = 0;
  int          mrow     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_write(int row, int col, int attr, int code);
    int a;
    int d;
    a = row * 128 + col;
    d = attr * 4096 + ((TB_BASE + code) % 1024);
    exp_q.push_back({16'(a), 16'(d)});
  endfunction

  function automatic void line_adv(int attr);
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      mrow = 0;
`ifdef TILE_TEXT_WRITER_ROWCLR_EN
      for (int c = 0; c < COLS; c++) push_write(0, c, attr, 32);
`endif
    end
  endfunction

  function automatic void model_byte(int d, int a);
    case (d)
      8'h0D: mcol = 0;
      8'h0A: line_adv(a);
      8'h08: if (mcol > 0) mcol--;
      8'h0C: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) push_write(r, c, a, 32);
        mcol = 0;
        mrow = 0;
      end
      default: begin
        push_write(mrow, mcol, a, d);
        if (mcol == COLS - 1) begin
          mcol = 0;
          line_adv(a);
        end else begin
          mcol++;
        end
      end
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (wr !== 2'b00) begin
      n_writes++;
      if (wr !== 2'b11) begin
        check("wr_strobe", int'(wr), 3);
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: address=%h dout=%h, none expected",
                 address, dout);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", int'(address), int'(e[31:16]));
        check("write_dout", int'(dout), int'(e[15:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic [3:0] a);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_attr  = a;
    model_byte(int'(d), int'(a));
    while (in_ready !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1",
               in_ready, w);
    end
    stall += w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (d != 8'h0C) begin
      check("cursor_col", int'(cursor_col), mcol);
      check("cursor_row", int'(cursor_row), mrow);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("drain_remaining", exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    int n;
    int r;
    logic [7:0] code;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_attr  = 4'h0;
    repeat (3) @(negedge clk);

    check("rst_wr", int'(wr), 0);
    check("rst_address", int'(address), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_cursor_col", int'(cursor_col), 0);
    check("rst_cursor_row", int'(cursor_row), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);

    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);

    // First character: expect address 0000, dout 5041, col 1.
    send(8'h41, 4'd5);
    drain();

    // A full row of 'B' from column 0 at full rate.
    send(8'h0D, 4'd0);
    stall = 0;
    for (int i = 0; i < COLS; i++) send(8'h42, 4'($urandom_range(0, 15)));
    check("row_stall_cycles", stall, 0);
    drain();

    // Control codes produce no writes.
    send(8'h43, 4'd1);
    drain();
    w0 = n_writes;
    send(8'h0D, 4'd2);
    send(8'h0A, 4'd2);
    send(8'h08, 4'd2);
    drain();
    check("ctrl_write_count", n_writes - w0, 0);

    // Form feed: full-screen clear.
    w0 = n_writes;
    send(8'h0C, 4'd3);
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("ff_busy_cycles", n, ROWS * COLS);
    drain();
    check("ff_write_count", n_writes - w0, ROWS * COLS);
    check("ff_cursor_col", int'(cursor_col), 0);
    check("ff_cursor_row", int'(cursor_row), 0);

    // LF on the last row.
    send(8'h0D, 4'd1);
    while (mrow != ROWS - 1) send(8'h0A, 4'd1);
    drain();
    w0 = n_writes;
    send(8'h0A, 4'd6);
    drain();
`ifdef TILE_TEXT_WRITER_ROWCLR_EN
    check("bottom_lf_writes", n_writes - w0, COLS);
`else
    check("bottom_lf_writes", n_writes - w0, 0);
`endif
    check("bottom_lf_row", int'(cursor_row), 0);

    // Randomized mix of printables and cursor controls.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        code = 8'($urandom_range(0, 255));
        if (code == 8'h08 || code == 8'h0A || code == 8'h0C || code == 8'h0D)
          code = 8'h41;
      end else if (r == 6) code = 8'h0D;
      else if (r == 7) code = 8'h0A;
      else if (r == 8) code = 8'h08;
      else code = 8'h20;
      send(code, 4'($urandom_range(0, 15)));
    end
    drain();

    // Reset in the middle of a clear.
    w0 = n_writes;
    send(8'h0C, 4'd2);
    n = 0;
    while (n_writes < w0 + 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_write_100", n_writes - w0, 100);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    #1;
    check("abort_wr", int'(wr), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    w0 = n_writes;
    repeat (30) @(negedge clk);
    check("abort_no_writes", n_writes - w0, 0);
    check("abort_cursor_col", int'(cursor_col), 0);
    check("abort_cursor_row", int'(cursor_row), 0);
    check("abort_in_ready", int'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
